// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants for the four-digit seven-segment scan controller:
// segment patterns, blank/off codes and scan FSM state encodings.
package display_scan_ctrl_pkg;

   typedef enum logic {
      ST_ON    = 1'b0,
      ST_BLANK = 1'b1
   } scan_state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [3:0] AN_OFF    = 4'b1111;

   // Active-low gfedcba patterns, index = hex value (entry 15 listed first)
   localparam logic [15:0][6:0] SEG_LUT = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/display_scan_ctrl_hex_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern (gfedcba).
module hex_seg_decoder
   import display_scan_ctrl_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg_c
);

   assign o_seg_c = SEG_LUT[i_nib];

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with dead-time blanking,
// frame-aligned double buffering and overflow blink.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYC    = 1000,
   parameter int unsigned BLINK_FRAMES = 125
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] val,
   input  logic [3:0]  en,
   input  logic        ovf,
   input  logic        load,
   output logic [6:0]  d,
   output logic [3:0]  AN,
   output logic        Overflow,
   output logic        frame_done
);

   localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   scan_state_t        r_state;
   logic [1:0]         r_sel;
   logic [CNT_W-1:0]   r_cnt;
   logic [15:0]        r_pend_val;
   logic [3:0]         r_pend_en;
   logic               r_pend_ovf;
   logic               r_pend_valid;
   logic [15:0]        r_act_val;
   logic [3:0]         r_act_en;
   logic               r_act_ovf;
   logic               r_blink_phase;
   logic [BLK_W-1:0]   r_blink_cnt;

   scan_state_t        w_nxt_state;
   logic [1:0]         w_nxt_sel;
   logic [CNT_W-1:0]   w_nxt_cnt;
   logic [15:0]        w_nxt_pend_val;
   logic [3:0]         w_nxt_pend_en;
   logic               w_nxt_pend_ovf;
   logic               w_nxt_pend_valid;
   logic [15:0]        w_nxt_act_val;
   logic [3:0]         w_nxt_act_en;
   logic               w_nxt_act_ovf;
   logic               w_nxt_blink_phase;
   logic [BLK_W-1:0]   w_nxt_blink_cnt;
   logic               w_frame;
   logic               w_lit;
   logic [3:0]         w_nib;
   logic [6:0]         w_seg;
   logic [3:0]         w_nxt_an;
   logic [6:0]         w_nxt_d;

   // Next-state logic; outputs are decoded from next state so the registered
   // outputs always match the state registers they sit beside.
   always_comb begin
      w_nxt_state       = r_state;
      w_nxt_sel         = r_sel;
      w_nxt_cnt         = r_cnt;
      w_nxt_pend_val    = r_pend_val;
      w_nxt_pend_en     = r_pend_en;
      w_nxt_pend_ovf    = r_pend_ovf;
      w_nxt_pend_valid  = r_pend_valid;
      w_nxt_act_val     = r_act_val;
      w_nxt_act_en      = r_act_en;
      w_nxt_act_ovf     = r_act_ovf;
      w_nxt_blink_phase = r_blink_phase;
      w_nxt_blink_cnt   = r_blink_cnt;
      w_frame           = 1'b0;

      case (r_state)
         ST_ON: begin
            if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
               w_nxt_state = ST_BLANK;
               w_nxt_cnt   = '0;
            end else begin
               w_nxt_cnt = r_cnt + CNT_W'(1);
            end
         end
         ST_BLANK: begin
            if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
               w_nxt_state = ST_ON;
               w_nxt_cnt   = '0;
               w_nxt_sel   = r_sel + 2'd1;
               w_frame     = (r_sel == 2'd3);
            end else begin
               w_nxt_cnt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_nxt_state = ST_ON;
            w_nxt_cnt   = '0;
         end
      endcase

      if (w_frame && r_pend_valid) begin
         w_nxt_act_val = r_pend_val;
         w_nxt_act_en  = r_pend_en;
         w_nxt_act_ovf = r_pend_ovf;
      end

      // A load on the boundary edge lands in pending for the following frame
      if (load) begin
         w_nxt_pend_val   = val;
         w_nxt_pend_en    = en;
         w_nxt_pend_ovf   = ovf;
         w_nxt_pend_valid = 1'b1;
      end else if (w_frame) begin
         w_nxt_pend_valid = 1'b0;
      end

      if (w_frame) begin
         if (!w_nxt_act_ovf) begin
            w_nxt_blink_phase = 1'b0;
            w_nxt_blink_cnt   = '0;
         end else if (r_blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
            w_nxt_blink_phase = ~r_blink_phase;
            w_nxt_blink_cnt   = '0;
         end else begin
            w_nxt_blink_cnt = r_blink_cnt + BLK_W'(1);
         end
      end
   end

   always_comb begin
      case (w_nxt_sel)
         2'd0:    w_nib = w_nxt_act_val[3:0];
         2'd1:    w_nib = w_nxt_act_val[7:4];
         2'd2:    w_nib = w_nxt_act_val[11:8];
         default: w_nib = w_nxt_act_val[15:12];
      endcase
   end

   hex_seg_decoder u_dec (
      .i_nib   (w_nib),
      .o_seg_c (w_seg)
   );

   assign w_lit    = (w_nxt_state == ST_ON) && w_nxt_act_en[w_nxt_sel] && !w_nxt_blink_phase;
   assign w_nxt_an = w_lit ? ~(4'b0001 << w_nxt_sel) : AN_OFF;
   assign w_nxt_d  = w_lit ? w_seg : SEG_BLANK;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_ON;
         r_sel         <= '0;
         r_cnt         <= '0;
         r_pend_val    <= '0;
         r_pend_en     <= '0;
         r_pend_ovf    <= 1'b0;
         r_pend_valid  <= 1'b0;
         r_act_val     <= '0;
         r_act_en      <= '0;
         r_act_ovf     <= 1'b0;
         r_blink_phase <= 1'b0;
         r_blink_cnt   <= '0;
         AN            <= AN_OFF;
         d             <= SEG_BLANK;
         Overflow      <= 1'b1;
         frame_done    <= 1'b0;
      end else begin
         r_state       <= w_nxt_state;
         r_sel         <= w_nxt_sel;
         r_cnt         <= w_nxt_cnt;
         r_pend_val    <= w_nxt_pend_val;
         r_pend_en     <= w_nxt_pend_en;
         r_pend_ovf    <= w_nxt_pend_ovf;
         r_pend_valid  <= w_nxt_pend_valid;
         r_act_val     <= w_nxt_act_val;
         r_act_en      <= w_nxt_act_en;
         r_act_ovf     <= w_nxt_act_ovf;
         r_blink_phase <= w_nxt_blink_phase;
         r_blink_cnt   <= w_nxt_blink_cnt;
         AN            <= w_nxt_an;
         d             <= w_nxt_d;
         Overflow      <= ~w_nxt_act_ovf;
         frame_done    <= w_frame;
      end
   end

endmodule
